// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges EXU results and LSU load data onto the single
// register-file write port, with one cycle of latency.
// The registered write is also forwarded to the operand-read addresses, and
// every register-file write is counted in commit_cnt.
// Optional build macro WB_ARBITER_RR_EN enables round-robin priority between
// the two sources. Without it, LSU always has priority over EXU.
//
// Priority state
//   state     | meaning
//   PRIO_LSU  | LSU wins when both sources are valid
//   PRIO_EXU  | EXU wins when both sources are valid (round-robin build only)
module wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_waddr,
   input  logic [DATA_WIDTH-1:0] exu_wdata,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] byp_raddr_1,
   input  logic [ADDR_WIDTH-1:0] byp_raddr_2,
   output logic                  byp_hit_1,
   output logic [DATA_WIDTH-1:0] byp_data_1,
   output logic                  byp_hit_2,
   output logic [DATA_WIDTH-1:0] byp_data_2,
   output logic [31:0]           commit_cnt
);

   typedef enum logic {PRIO_LSU = 1'b0, PRIO_EXU = 1'b1} prio_t;

   prio_t                 prio;
   logic                  grant_lsu;
   logic                  grant_exu;
   logic [ADDR_WIDTH-1:0] sel_waddr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Grant decode; readies are held low while reset is asserted.
   always_comb begin
      grant_lsu = 1'b0;
      grant_exu = 1'b0;
      if (rst_n) begin
         grant_lsu = lsu_valid && (!exu_valid || (prio == PRIO_LSU));
         grant_exu = exu_valid && (!lsu_valid || (prio == PRIO_EXU));
      end
   end

   assign lsu_ready = grant_lsu;
   assign exu_ready = grant_exu;

   // Mux the granted source onto the write-back path.
   always_comb begin
      sel_waddr = exu_waddr;
      sel_wdata = exu_wdata;
      if (grant_lsu) begin
         sel_waddr = lsu_waddr;
         sel_wdata = lsu_wdata;
      end
   end

`ifdef WB_ARBITER_RR_EN
   // Round-robin: after each transfer, the source that was not granted gets priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= PRIO_LSU;
      end else if (grant_lsu) begin
         prio <= PRIO_EXU;
      end else if (grant_exu) begin
         prio <= PRIO_LSU;
      end
   end
`else
   // Fixed priority: LSU always wins.
   assign prio = PRIO_LSU;
`endif

   // Register the granted write. Writes to address 0 are accepted but
   // do not produce an rf_wen pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= (grant_lsu || grant_exu) && (sel_waddr != '0);
         if (grant_lsu || grant_exu) begin
            rf_waddr <= sel_waddr;
            rf_wdata <= sel_wdata;
         end
      end
   end

   // Count register-file writes; the counter wraps naturally at 32 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_cnt <= '0;
      end else if (rf_wen) begin
         commit_cnt <= commit_cnt + 32'd1;
      end
   end

   // Forward the in-flight write to the read ports. Address 0 never hits.
   always_comb begin
      byp_hit_1  = rf_wen && (rf_waddr != '0) && (rf_waddr == byp_raddr_1);
      byp_hit_2  = rf_wen && (rf_waddr != '0) && (rf_waddr == byp_raddr_2);
      byp_data_1 = byp_hit_1 ? rf_wdata : '0;
      byp_data_2 = byp_hit_2 ? rf_wdata : '0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter. Expected write-back results are queued when stimulus
// is driven and compared one cycle later. Works with or without
// WB_ARBITER_RR_EN defined.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exu_valid, lsu_valid;
   logic        exu_ready, lsu_ready;
   logic [4:0]  exu_waddr, lsu_waddr;
   logic [31:0] exu_wdata, lsu_wdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  byp_raddr_1, byp_raddr_2;
   logic        byp_hit_1, byp_hit_2;
   logic [31:0] byp_data_1, byp_data_2;
   logic [31:0] commit_cnt;

   typedef struct {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_cnt;
   logic        m_wen;
   logic        m_prio_exu;

   wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .exu_valid(exu_valid), .exu_ready(exu_ready),
      .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .byp_raddr_1(byp_raddr_1), .byp_raddr_2(byp_raddr_2),
      .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
      .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
      .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_idle_after_reset();
      exp_t e;
      e.wen  = 1'b0;
      e.addr = '0;
      e.data = '0;
      e.cnt  = '0;
      sb_q.delete();
      sb_q.push_back(e);
      m_cnt      = '0;
      m_wen      = 1'b0;
      m_prio_exu = 1'b0;
   endtask

   // One cycle: check the result of the previous edge, then drive new inputs and queue the expected outcome.
   task automatic step(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
      exp_t e, n;
      logic gl, ge, h1, h2;
      @(negedge clk);
      exu_valid = ev; exu_waddr = ea; exu_wdata = ed;
      lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
      byp_raddr_1 = r1; byp_raddr_2 = r2;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("rf_wen", {31'b0, rf_wen}, {31'b0, e.wen});
         if (e.wen) begin
            chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.addr});
            chk("rf_wdata", rf_wdata, e.data);
         end
         chk("commit_cnt", commit_cnt, e.cnt);
         h1 = e.wen && (e.addr == r1);
         h2 = e.wen && (e.addr == r2);
         chk("byp_hit_1", {31'b0, byp_hit_1}, {31'b0, h1});
         chk("byp_data_1", byp_data_1, h1 ? e.data : 32'h0);
         chk("byp_hit_2", {31'b0, byp_hit_2}, {31'b0, h2});
         chk("byp_data_2", byp_data_2, h2 ? e.data : 32'h0);
      end
      gl = lv && (!ev || !m_prio_exu);
      ge = ev && (!lv || m_prio_exu);
      chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, gl});
      chk("exu_ready", {31'b0, exu_ready}, {31'b0, ge});
      n.wen  = (gl && (la != 5'd0)) || (ge && (ea != 5'd0));
      n.addr = gl ? la : ea;
      n.data = gl ? ld : ed;
      n.cnt  = m_cnt + {31'b0, m_wen};
      m_cnt  = n.cnt;
      m_wen  = n.wen;
      sb_q.push_back(n);
`ifdef WB_ARBITER_RR_EN
      if (gl) m_prio_exu = 1'b1;
      else if (ge) m_prio_exu = 1'b0;
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      exu_valid = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'h1;
      lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h2;
      byp_raddr_1 = 5'd0; byp_raddr_2 = 5'd0;
      #3;
      chk("rst_rf_wen", {31'b0, rf_wen}, 32'h0);
      chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'h0);
      chk("rst_rf_wdata", rf_wdata, 32'h0);
      chk("rst_commit_cnt", commit_cnt, 32'h0);
      chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'h0);
      chk("rst_exu_ready", {31'b0, exu_ready}, 32'h0);
      exu_valid = 1'b0; lsu_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      push_idle_after_reset();

      // Single LSU load write-back.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
      idle(2);

      // Both sources valid for two transfers, then EXU drains.
      step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
      step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
      step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
      idle(1);

      // Write to address 0 is accepted but does not commit.
      step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      idle(2);

      // Forwarding: hit on port 1, miss on port 2.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE, 5'd0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);

      // Back-to-back EXU writes.
      for (int i = 1; i < 6; i++)
         step(1'b1, 5'(i), 32'(i * 32'h101), 1'b0, 5'd0, 32'h0, 5'(i - 1), 5'(i));

      // Random traffic.
      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      idle(2);

      // Reset in the middle of the cycle that would commit a transfer.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
      @(posedge clk);
      #2;
      exu_valid = 1'b1; exu_waddr = 5'd4;
      lsu_valid = 1'b1; lsu_waddr = 5'd4;
      rst_n = 1'b0;
      #1;
      chk("midrst_rf_wen", {31'b0, rf_wen}, 32'h0);
      chk("midrst_commit_cnt", commit_cnt, 32'h0);
      chk("midrst_rf_waddr", {27'b0, rf_waddr}, 32'h0);
      chk("midrst_lsu_ready", {31'b0, lsu_ready}, 32'h0);
      chk("midrst_exu_ready", {31'b0, exu_ready}, 32'h0);
      exu_valid = 1'b0; lsu_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      push_idle_after_reset();
      idle(2);

      // Counter wrap: preload the counter to all ones, then commit one more write.
      force dut.commit_cnt = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      release dut.commit_cnt;
      e = sb_q.pop_back();
      e.cnt = 32'hFFFFFFFF;
      sb_q.push_back(e);
      m_cnt = 32'hFFFFFFFF;
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h77, 5'd2, 5'd0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
